control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 5: instruction opcode from datapath IR logic; valid from T3 onward.
REQ-004 SHALL have port con_ff, input, 1: branch condition from CON flip-flop.
REQ-005 SHALL have port stop, input, 1: request halt at next instruction boundary.
REQ-006 SHALL have port run, output, 1: high while executing, low in RESET and HALT.
REQ-007 SHALL have outputs Gra, Grb, Grc, R_enable, Rout, BAout, each 1: register-select and register-file strobes.
REQ-008 SHALL have outputs PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, each 1: bus-driver selects.
REQ-009 SHALL have outputs enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableHI, enableLO, enableCON, enableInPort, enableOutPort, each 1: register load strobes.
REQ-010 SHALL have outputs IncPC, 1, and RAM_write, 1.
REQ-011 SHALL have output MDR_read, 3: MDR mux select; MDR_SEL_BUS=0, MDR_SEL_RAM=1, MDR_SEL_EXT=2.

Function
REQ-012 SHALL be a Moore FSM; outputs depend only on state and the opcode latched at T3; every output not listed for a state is 0; MDR_read defaults to MDR_SEL_BUS.
REQ-013 SHALL use states RESET, T0..T7, HALT; at most one bus-driver select asserted per cycle.
REQ-014 Fetch SHALL be: T0 PCout,enableMAR,IncPC,enableZ; T1 ZLowout,enablePC,MDR_read=RAM,enableMDR; T2 MDRout,enableIR; T2 always goes to T3.
REQ-015 R-ALU (00011-01010) SHALL be: T3 Grb,Rout,enableY; T4 Grc,Rout,enableZ; T5 ZLowout,Gra,R_enable.
REQ-016 Immediate (01011-01101) SHALL be: T3 Grb,Rout,enableY; T4 Cout,enableZ; T5 ZLowout,Gra,R_enable.
REQ-017 mul/div (01110,01111) SHALL be: T3 Gra,Rout,enableY; T4 Grb,Rout,enableZ; T5 ZLowout,enableLO; T6 ZHighout,enableHI.
REQ-018 neg/not (10000,10001) SHALL be: T3 Grb,Rout,enableZ; T4 ZLowout,Gra,R_enable.
REQ-019 ld (00000) SHALL be: T3 Grb,BAout,Rout,enableY; T4 Cout,enableZ; T5 ZLowout,enableMAR; T6 MDR_read=RAM,enableMDR; T7 MDRout,Gra,R_enable. ldi (00001) SHALL stop after T5 with ZLowout,Gra,R_enable.
REQ-020 st (00010) SHALL be ld T3-T5, then T6 Gra,Rout,MDR_read=BUS,enableMDR; T7 RAM_write.
REQ-021 brx (10010) SHALL be: T3 Gra,Rout,enableCON; T4 PCout,enableY; T5 Cout,enableZ; T6 ZLowout and enablePC only if con_ff=1.
REQ-022 jr (10011): T3 Gra,Rout,enablePC. mfhi (10111)/mflo (11000): T3 HIout/LOout,Gra,R_enable.
REQ-023 nop (11001), jal (10100) and all unlisted opcodes SHALL execute as nop: T3 no strobes.
REQ-024 Last step of each class SHALL return to T0; maximum instruction length 8 cycles.
REQ-025 halt (11010) at T3 SHALL go to HALT; stop=1 sampled in T0 SHALL go to HALT instead of T1; HALT holds all strobes 0 until clr.
REQ-026 stop asserted mid-instruction SHALL not take effect until the next T0.

Reset
REQ-027 clr=1 at a rising edge SHALL force RESET regardless of state, abandoning any instruction; no strobe, RAM_write or enablePC asserted in RESET; run=0.
REQ-028 RESET SHALL go to T0 on the first edge with clr=0.

Configuration
REQ-029 With CONTROL_IO_EN defined: in (10101) T3 InPortout,Gra,R_enable; out (10110) T3 Gra,Rout,enableOutPort; enableInPort=1 in every state except RESET/HALT.
REQ-030 Without CONTROL_IO_EN: in/out execute as nop; enableInPort, enableOutPort, InPortout tied 0.

Structure
REQ-031 Opcode constants, state encodings and MDR_SEL_* constants SHALL live in shared package control_defs.
REQ-032 Opcode-to-class decode SHALL be one combinational sub-module, control_decode.

Verification
REQ-033 add (00011) after clr release -> strobes per REQ-014/015 at cycles T0-T5; T0 again at 7th cycle; RAM_write never 1.
REQ-034 ld (00000) -> MDR_read=1 with enableMDR only at T1 and T6; R_enable only at T7.
REQ-035 brx with con_ff=0 -> enablePC only at T1; with con_ff=1 -> enablePC at T1 and T6.
REQ-036 halt (11010) -> run falls after T3, all strobes 0 for 100 cycles, T0 resumes 2 cycles after clr pulse.
REQ-037 clr asserted during T4 of mul -> RESET next cycle, enableLO/enableHI never asserted, T0 follows.
REQ-038 out (10110) -> enableOutPort at T3 with CONTROL_IO_EN; no strobe at T3 without it.

Source files
------------

// File: rtl/control_defs.sv
// Shared definitions for the control unit: opcodes, FSM state encoding,
// instruction classes and MDR mux selects.
package control_defs;

    // MDR input mux selects
    localparam logic [2:0] MDR_SEL_BUS = 3'd0;
    localparam logic [2:0] MDR_SEL_RAM = 3'd1;
    localparam logic [2:0] MDR_SEL_EXT = 3'd2;

    // Opcodes
    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpRlast = 5'b01010;
    localparam logic [4:0] OpAddi = 5'b01011;
    localparam logic [4:0] OpIlast = 5'b01101;
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpNeg  = 5'b10000;
    localparam logic [4:0] OpNot  = 5'b10001;
    localparam logic [4:0] OpBrx  = 5'b10010;
    localparam logic [4:0] OpJr   = 5'b10011;
    localparam logic [4:0] OpJal  = 5'b10100;
    localparam logic [4:0] OpIn   = 5'b10101;
    localparam logic [4:0] OpOut  = 5'b10110;
    localparam logic [4:0] OpMfhi = 5'b10111;
    localparam logic [4:0] OpMflo = 5'b11000;
    localparam logic [4:0] OpNop  = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11010;

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNop, ClsRalu, ClsImm, ClsMulDiv, ClsNegNot, ClsLd, ClsLdi, ClsSt,
        ClsBr, ClsJr, ClsMfhi, ClsMflo, ClsHalt, ClsIn, ClsOut
    } cls_e;

    // Final execute step of each class; the FSM returns to T0 after it.
    function automatic state_e last_step(input cls_e cls);
        case (cls)
            ClsNegNot:                 last_step = StT4;
            ClsRalu, ClsImm, ClsLdi:   last_step = StT5;
            ClsMulDiv, ClsBr:          last_step = StT6;
            ClsLd, ClsSt:              last_step = StT7;
            default:                   last_step = StT3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath signal bundle. The master side is the control unit.
interface control_unit_if;
    logic [4:0] opcode;
    logic       con_ff;
    logic       stop;
    logic       run;
    logic       Gra, Grb, Grc, R_enable, Rout, BAout;
    logic       PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout;
    logic       enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC;
    logic       enableHI, enableLO, enableCON, enableInPort, enableOutPort;
    logic       IncPC, RAM_write;
    logic [2:0] MDR_read;

    modport master (
        input  opcode, con_ff, stop,
        output run, Gra, Grb, Grc, R_enable, Rout, BAout,
        output PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout,
        output enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC,
        output enableHI, enableLO, enableCON, enableInPort, enableOutPort,
        output IncPC, RAM_write, MDR_read
    );

    modport slave (
        output opcode, con_ff, stop,
        input  run, Gra, Grb, Grc, R_enable, Rout, BAout,
        input  PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout,
        input  enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC,
        input  enableHI, enableLO, enableCON, enableInPort, enableOutPort,
        input  IncPC, RAM_write, MDR_read
    );
endinterface

// File: rtl/control_decode.sv
// Opcode to instruction-class decode. in/out map to their own classes only
// when CONTROL_IO_EN is defined; otherwise they decode as nop.
module control_decode
    import control_defs::*;
(
    input  logic [4:0] opcode,
    output cls_e       cls
);

    // Pure combinational class lookup; unlisted opcodes fall through to nop.
    always_comb begin
        cls = ClsNop;
        if (opcode >= OpAdd && opcode <= OpRlast) begin
            cls = ClsRalu;
        end else if (opcode >= OpAddi && opcode <= OpIlast) begin
            cls = ClsImm;
        end else begin
            case (opcode)
                OpLd:          cls = ClsLd;
                OpLdi:         cls = ClsLdi;
                OpSt:          cls = ClsSt;
                OpMul, OpDiv:  cls = ClsMulDiv;
                OpNeg, OpNot:  cls = ClsNegNot;
                OpBrx:         cls = ClsBr;
                OpJr:          cls = ClsJr;
                OpMfhi:        cls = ClsMfhi;
                OpMflo:        cls = ClsMflo;
                OpHalt:        cls = ClsHalt;
`ifdef CONTROL_IO_EN
                OpIn:          cls = ClsIn;
                OpOut:         cls = ClsOut;
`endif
                default:       cls = ClsNop;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore FSM control unit: fetch T0-T2, class-dependent execute T3-T7, HALT.
// Optional macro CONTROL_IO_EN enables the in/out instructions and the
// free-running InPort load strobe.
module control_unit
    import control_defs::*;
(
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu
);

    state_e state_q;
    cls_e   cls_q;
    cls_e   dec_cls;
    cls_e   cls;
    logic   con_q;
    logic   running;

    control_decode u_decode (
        .opcode (cu.opcode),
        .cls    (dec_cls)
    );

    // IR output only settles in T3, so T3 uses the live decode; later steps use the latch.
    assign cls     = (state_q == StT3) ? dec_cls : cls_q;
    assign running = (state_q != StReset) && (state_q != StHalt);

    // State sequencing, class latch at T3 and branch condition capture at T5.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StReset;
            cls_q   <= ClsNop;
            con_q   <= 1'b0;
        end else begin
            case (state_q)
                StReset: state_q <= StT0;
                StT0:    state_q <= cu.stop ? StHalt : StT1;
                StT1:    state_q <= StT2;
                StT2:    state_q <= StT3;
                StT3, StT4, StT5, StT6, StT7: begin
                    if (cls == ClsHalt) begin
                        state_q <= StHalt;
                    end else if (state_q == last_step(cls)) begin
                        state_q <= StT0;
                    end else begin
                        state_q <= state_e'(state_q + 4'd1);
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StReset;
            endcase
            if (state_q == StT3) cls_q <= dec_cls;
            if (state_q == StT5) con_q <= cu.con_ff;
        end
    end

    // Output decode from state and latched class; every strobe defaults low.
    always_comb begin
        cu.run           = running;
        cu.Gra           = 1'b0;
        cu.Grb           = 1'b0;
        cu.Grc           = 1'b0;
        cu.R_enable      = 1'b0;
        cu.Rout          = 1'b0;
        cu.BAout         = 1'b0;
        cu.PCout         = 1'b0;
        cu.MDRout        = 1'b0;
        cu.ZLowout       = 1'b0;
        cu.ZHighout      = 1'b0;
        cu.HIout         = 1'b0;
        cu.LOout         = 1'b0;
        cu.InPortout     = 1'b0;
        cu.Cout          = 1'b0;
        cu.enableMAR     = 1'b0;
        cu.enableMDR     = 1'b0;
        cu.enableIR      = 1'b0;
        cu.enableY       = 1'b0;
        cu.enableZ       = 1'b0;
        cu.enablePC      = 1'b0;
        cu.enableHI      = 1'b0;
        cu.enableLO      = 1'b0;
        cu.enableCON     = 1'b0;
        cu.enableOutPort = 1'b0;
        cu.IncPC         = 1'b0;
        cu.RAM_write     = 1'b0;
        cu.MDR_read      = MDR_SEL_BUS;
`ifdef CONTROL_IO_EN
        cu.enableInPort  = running;
`else
        cu.enableInPort  = 1'b0;
`endif
        case (state_q)
            StT0: begin
                cu.PCout = 1'b1; cu.enableMAR = 1'b1; cu.IncPC = 1'b1; cu.enableZ = 1'b1;
            end
            StT1: begin
                cu.ZLowout = 1'b1; cu.enablePC = 1'b1;
                cu.MDR_read = MDR_SEL_RAM; cu.enableMDR = 1'b1;
            end
            StT2: begin
                cu.MDRout = 1'b1; cu.enableIR = 1'b1;
            end
            StT3: begin
                case (cls)
                    ClsRalu, ClsImm: begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableY = 1'b1; end
                    ClsMulDiv: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableY = 1'b1; end
                    ClsNegNot: begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                    ClsLd, ClsLdi, ClsSt: begin
                        cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Rout = 1'b1; cu.enableY = 1'b1;
                    end
                    ClsBr: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableCON = 1'b1; end
                    ClsJr: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enablePC = 1'b1; end
                    ClsMfhi: begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                    ClsMflo: begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
`ifdef CONTROL_IO_EN
                    ClsIn: begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                    ClsOut: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableOutPort = 1'b1; end
`endif
                    default: ;
                endcase
            end
            StT4: begin
                case (cls)
                    ClsRalu: begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                    ClsImm, ClsLd, ClsLdi, ClsSt: begin cu.Cout = 1'b1; cu.enableZ = 1'b1; end
                    ClsMulDiv: begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                    ClsNegNot: begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                    ClsBr: begin cu.PCout = 1'b1; cu.enableY = 1'b1; end
                    default: ;
                endcase
            end
            StT5: begin
                case (cls)
                    ClsRalu, ClsImm, ClsLdi: begin
                        cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1;
                    end
                    ClsMulDiv: begin cu.ZLowout = 1'b1; cu.enableLO = 1'b1; end
                    ClsLd, ClsSt: begin cu.ZLowout = 1'b1; cu.enableMAR = 1'b1; end
                    ClsBr: begin cu.Cout = 1'b1; cu.enableZ = 1'b1; end
                    default: ;
                endcase
            end
            StT6: begin
                case (cls)
                    ClsMulDiv: begin cu.ZHighout = 1'b1; cu.enableHI = 1'b1; end
                    ClsLd: begin cu.MDR_read = MDR_SEL_RAM; cu.enableMDR = 1'b1; end
                    ClsSt: begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableMDR = 1'b1; end
                    ClsBr: begin cu.ZLowout = con_q; cu.enablePC = con_q; end
                    default: ;
                endcase
            end
            StT7: begin
                case (cls)
                    ClsLd: begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                    ClsSt: cu.RAM_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction stream against a
// per-instruction step table, checked every cycle, plus literal pin checks.
module tb_control_unit;

    // Bit positions of the packed strobe vector (MDR_read occupies [29:27]).
    localparam logic [29:0] BGra   = 30'd1 << 0;
    localparam logic [29:0] BGrb   = 30'd1 << 1;
    localparam logic [29:0] BGrc   = 30'd1 << 2;
    localparam logic [29:0] BRen   = 30'd1 << 3;
    localparam logic [29:0] BRout  = 30'd1 << 4;
    localparam logic [29:0] BBaout = 30'd1 << 5;
    localparam logic [29:0] BPcout = 30'd1 << 6;
    localparam logic [29:0] BMdrout = 30'd1 << 7;
    localparam logic [29:0] BZlo   = 30'd1 << 8;
    localparam logic [29:0] BZhi   = 30'd1 << 9;
    localparam logic [29:0] BHiout = 30'd1 << 10;
    localparam logic [29:0] BLoout = 30'd1 << 11;
    localparam logic [29:0] BInpout = 30'd1 << 12;
    localparam logic [29:0] BCout  = 30'd1 << 13;
    localparam logic [29:0] BEmar  = 30'd1 << 14;
    localparam logic [29:0] BEmdr  = 30'd1 << 15;
    localparam logic [29:0] BEir   = 30'd1 << 16;
    localparam logic [29:0] BEy    = 30'd1 << 17;
    localparam logic [29:0] BEz    = 30'd1 << 18;
    localparam logic [29:0] BEpc   = 30'd1 << 19;
    localparam logic [29:0] BEhi   = 30'd1 << 20;
    localparam logic [29:0] BElo   = 30'd1 << 21;
    localparam logic [29:0] BEcon  = 30'd1 << 22;
    localparam logic [29:0] BEinp  = 30'd1 << 23;
    localparam logic [29:0] BEoutp = 30'd1 << 24;
    localparam logic [29:0] BIncpc = 30'd1 << 25;
    localparam logic [29:0] BRamw  = 30'd1 << 26;
    localparam logic [29:0] MdrRam = 30'd1 << 27;
    localparam logic [29:0] Drivers = BPcout | BMdrout | BZlo | BZhi | BHiout | BLoout |
                                      BInpout | BCout;
`ifdef CONTROL_IO_EN
    localparam logic [29:0] IoBase = BEinp;
`else
    localparam logic [29:0] IoBase = 30'd0;
`endif

    logic clk;
    logic clr;
    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .clr (clr),
        .cu  (bus)
    );

    logic [29:0] dut_vec;
    assign dut_vec = {bus.MDR_read, bus.RAM_write, bus.IncPC, bus.enableOutPort,
                      bus.enableInPort, bus.enableCON, bus.enableLO, bus.enableHI,
                      bus.enablePC, bus.enableZ, bus.enableY, bus.enableIR, bus.enableMDR,
                      bus.enableMAR, bus.Cout, bus.InPortout, bus.LOout, bus.HIout,
                      bus.ZHighout, bus.ZLowout, bus.MDRout, bus.PCout, bus.BAout, bus.Rout,
                      bus.R_enable, bus.Grc, bus.Grb, bus.Gra};

    int          n_checks = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;
    logic [29:0] exp_vec = '0;
    logic        exp_run = 1'b0;
    logic        pin_en = 1'b0;
    logic [29:0] pin_val = '0;

    logic [29:0] seq [8];
    int          seq_len;
    logic        seq_halt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every-cycle comparison against the expected step, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL strobes t=%0t actual=%h required=%h", $time, dut_vec, exp_vec);
            end
            n_checks++;
            if (bus.run !== exp_run) begin
                n_fail++;
                $display("FAIL run t=%0t actual=%b required=%b", $time, bus.run, exp_run);
            end
            n_checks++;
            if ($countones(dut_vec & Drivers) > 1) begin
                n_fail++;
                $display("FAIL one_driver t=%0t actual=%h required=at most one bus driver",
                         $time, dut_vec & Drivers);
            end
            if (pin_en) begin
                n_checks++;
                if (dut_vec !== pin_val) begin
                    n_fail++;
                    $display("FAIL pin t=%0t actual=%h required=%h", $time, dut_vec, pin_val);
                end
            end
        end
    end

    // Expected step sequence for one instruction, straight from the step tables.
    task automatic build_seq(input logic [4:0] op, input logic con);
        for (int i = 0; i < 8; i++) seq[i] = '0;
        seq[0] = BPcout | BEmar | BIncpc | BEz;
        seq[1] = BZlo | BEpc | MdrRam | BEmdr;
        seq[2] = BMdrout | BEir;
        seq_len = 4;
        seq_halt = 1'b0;
        if (op >= 5'd3 && op <= 5'd10) begin
            seq[3] = BGrb | BRout | BEy; seq[4] = BGrc | BRout | BEz;
            seq[5] = BZlo | BGra | BRen; seq_len = 6;
        end else if (op >= 5'd11 && op <= 5'd13) begin
            seq[3] = BGrb | BRout | BEy; seq[4] = BCout | BEz;
            seq[5] = BZlo | BGra | BRen; seq_len = 6;
        end else if (op == 5'd14 || op == 5'd15) begin
            seq[3] = BGra | BRout | BEy; seq[4] = BGrb | BRout | BEz;
            seq[5] = BZlo | BElo; seq[6] = BZhi | BEhi; seq_len = 7;
        end else if (op == 5'd16 || op == 5'd17) begin
            seq[3] = BGrb | BRout | BEz; seq[4] = BZlo | BGra | BRen; seq_len = 5;
        end else if (op <= 5'd2) begin
            seq[3] = BGrb | BBaout | BRout | BEy; seq[4] = BCout | BEz;
            if (op == 5'd1) begin
                seq[5] = BZlo | BGra | BRen; seq_len = 6;
            end else if (op == 5'd0) begin
                seq[5] = BZlo | BEmar; seq[6] = MdrRam | BEmdr;
                seq[7] = BMdrout | BGra | BRen; seq_len = 8;
            end else begin
                seq[5] = BZlo | BEmar; seq[6] = BGra | BRout | BEmdr;
                seq[7] = BRamw; seq_len = 8;
            end
        end else if (op == 5'd18) begin
            seq[3] = BGra | BRout | BEcon; seq[4] = BPcout | BEy; seq[5] = BCout | BEz;
            seq[6] = con ? (BZlo | BEpc) : 30'd0; seq_len = 7;
        end else if (op == 5'd19) begin
            seq[3] = BGra | BRout | BEpc;
        end else if (op == 5'd23) begin
            seq[3] = BHiout | BGra | BRen;
        end else if (op == 5'd24) begin
            seq[3] = BLoout | BGra | BRen;
        end else if (op == 5'd26) begin
            seq_halt = 1'b1;
`ifdef CONTROL_IO_EN
        end else if (op == 5'd21) begin
            seq[3] = BInpout | BGra | BRen;
        end else if (op == 5'd22) begin
            seq[3] = BGra | BRout | BEoutp;
`endif
        end
        for (int i = 0; i < 8; i++) seq[i] = seq[i] | IoBase;
    endtask

    // One clock cycle with the given expectation; returns 1 ns after the rising edge.
    task automatic cyc(input logic [29:0] v, input logic r);
        exp_vec = v;
        exp_run = r;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    // Runs one instruction from T0. opcode only carries the real value in T3.
    task automatic run_instr(input logic [4:0] op, input logic con, input int stop_at,
                             input int abort_at, input int pin_k, input logic [29:0] pin_lit);
        build_seq(op, con);
        bus.con_ff = con;
        for (int k = 0; k < seq_len; k++) begin
            bus.opcode = (k == 3) ? op : ~op;
            if (k == stop_at) bus.stop = 1'b1;
            if (k == abort_at) clr = 1'b1;
            if (k == pin_k) begin
                pin_en = 1'b1;
                pin_val = pin_lit | IoBase;
            end
            cyc(seq[k], 1'b1);
            if (k == abort_at) begin
                clr = 1'b0;
                cyc(30'd0, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        clr = 1'b1;
        bus.stop = 1'b0;
        bus.opcode = 5'd0;
        bus.con_ff = 1'b0;
        @(posedge clk);
        #1;
        // RESET held, then released: T0 follows the first edge with clr low.
        cyc(30'd0, 1'b0);
        clr = 1'b0;
        cyc(30'd0, 1'b0);

        run_instr(5'b00011, 1'b0, -1, -1, 0, 30'h0204_4040);   // add
        run_instr(5'b01010, 1'b0, -1, -1, 5, 30'h0000_0109);   // last R-ALU
        run_instr(5'b01011, 1'b0, -1, -1, -1, 30'd0);          // addi
        run_instr(5'b01110, 1'b0, -1, -1, 5, 30'h0020_0100);   // mul
        run_instr(5'b01111, 1'b0, -1, -1, -1, 30'd0);          // div
        run_instr(5'b10001, 1'b0, -1, -1, -1, 30'd0);          // not
        run_instr(5'b00000, 1'b0, -1, -1, 6, 30'h0800_8000);   // ld
        run_instr(5'b00001, 1'b0, -1, -1, 5, 30'h0000_0109);   // ldi
        run_instr(5'b00010, 1'b0, -1, -1, 7, 30'h0400_0000);   // st
        run_instr(5'b10010, 1'b0, -1, -1, 6, 30'h0000_0000);   // brx not taken
        run_instr(5'b10010, 1'b1, -1, -1, 6, 30'h0008_0100);   // brx taken
        run_instr(5'b10011, 1'b0, -1, -1, -1, 30'd0);          // jr
        run_instr(5'b10111, 1'b0, -1, -1, -1, 30'd0);          // mfhi
        run_instr(5'b11000, 1'b0, -1, -1, -1, 30'd0);          // mflo
        run_instr(5'b11001, 1'b0, -1, -1, -1, 30'd0);          // nop
        run_instr(5'b10100, 1'b0, -1, -1, -1, 30'd0);          // jal as nop
        run_instr(5'b10101, 1'b0, -1, -1, -1, 30'd0);          // in
`ifdef CONTROL_IO_EN
        run_instr(5'b10110, 1'b0, -1, -1, 3, 30'h0100_0011);   // out
`else
        run_instr(5'b10110, 1'b0, -1, -1, 3, 30'h0000_0000);   // out as nop
`endif
        run_instr(5'b11111, 1'b0, -1, -1, -1, 30'd0);          // unlisted

        // clr during T4 of mul abandons it before LO/HI are loaded.
        run_instr(5'b01110, 1'b0, -1, 4, -1, 30'd0);
        run_instr(5'b00011, 1'b0, -1, -1, -1, 30'd0);

        // halt: HALT after T3, strobes stay low, clr pulse restarts at T0.
        run_instr(5'b11010, 1'b0, -1, -1, -1, 30'd0);
        for (int i = 0; i < 100; i++) cyc(30'd0, 1'b0);
        clr = 1'b1;
        cyc(30'd0, 1'b0);
        clr = 1'b0;
        cyc(30'd0, 1'b0);
        run_instr(5'b01100, 1'b0, -1, -1, -1, 30'd0);

        // stop raised at T4 of mul waits for the next T0, then HALT.
        run_instr(5'b01110, 1'b0, 4, -1, -1, 30'd0);
        cyc(seq[0], 1'b1);
        bus.stop = 1'b0;
        for (int i = 0; i < 4; i++) cyc(30'd0, 1'b0);
        clr = 1'b1;
        cyc(30'd0, 1'b0);
        clr = 1'b0;
        cyc(30'd0, 1'b0);
        run_instr(5'b10000, 1'b0, -1, -1, -1, 30'd0);          // neg

        chk_en = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
